// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: single-clock FIFO with optional packet (frame) commit/drop.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   wr_en, din, wr_last       write request, data, end-of-frame marker (commits in packet mode)
//   wr_drop                   rewind the in-progress (uncommitted) frame
//   full                      no free entry
//   rd_en, dout, dout_last    read request, read data and its stored last flag
//   empty                     no readable word
//   data_count                readable (committed) words
//   wr_count                  total occupancy, committed plus uncommitted
//   pkt_count                 complete frames held
//   prog_full, prog_empty     programmable thresholds on wr_count / data_count
//   overflow, underflow       one-cycle pulse after a rejected write / read
//
// READ_MODE "fwft" prefetches committed words into the output register; "std" updates dout
// one cycle after an accepted rd_en. All flags and counts are registered next-state values.
module sync_pkt_fifo #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned DEPTH             = 2048,
  parameter string       READ_MODE         = "fwft",
  parameter int unsigned PKT_MODE          = 1,
  parameter int unsigned PROG_FULL_THRESH  = DEPTH - 16,
  parameter int unsigned PROG_EMPTY_THRESH = 8,
  parameter int unsigned CNT_WIDTH         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_last,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned          AddrWidth    = $clog2(DEPTH);
  localparam bit                   Fwft         = (READ_MODE == "fwft");
  localparam bit                   PktMode      = (PKT_MODE != 0);
  localparam logic [CNT_WIDTH-1:0] DepthCnt     = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ProgFullCnt  = CNT_WIDTH'(PROG_FULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] ProgEmptyCnt = CNT_WIDTH'(PROG_EMPTY_THRESH);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  // Shadow of the stored last flags so std-mode frame accounting can see the popped word's
  // flag in the same cycle without an asynchronous read of the main RAM.
  logic [DEPTH-1:0]      last_q;

  logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  commit_ptr_q, commit_ptr_d;
  logic [CNT_WIDTH-1:0]  commit_rd_q;
  logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_last_q;

  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  prog_full_q, prog_full_d;
  logic                  prog_empty_q, prog_empty_d;
  logic                  overflow_q, underflow_q;
  logic [CNT_WIDTH-1:0]  data_count_q, data_count_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

  logic                  drop, wr_accept, wr_reject, commit;
  logic                  pop, rd_reject, rd_load, pop_last;
  logic [AddrWidth-1:0]  wr_addr, rd_addr;
  logic [CNT_WIDTH-1:0]  out_cnt;

  always_comb begin
    wr_addr   = wr_ptr_q[AddrWidth-1:0];
    rd_addr   = rd_ptr_q[AddrWidth-1:0];
    // Drop takes priority over any word presented in the same cycle.
    drop      = PktMode & wr_drop;
    wr_accept = wr_en & ~full_q & ~drop;
    wr_reject = wr_en & full_q & ~drop;
    commit    = wr_accept & wr_last;
    pop       = rd_en & ~empty_q;
    rd_reject = rd_en & empty_q;

    if (Fwft) begin
      // Refill the output register whenever it is free or being popped. The read side works
      // from commit_rd_q, a one-cycle-late view of commit_ptr, so a commit becomes visible
      // on dout two edges after the commit edge.
      rd_load     = (~out_valid_q | pop) & (commit_rd_q != rd_ptr_q);
      out_valid_d = rd_load | (out_valid_q & ~pop);
      pop_last    = pop & dout_last_q;
    end else begin
      rd_load     = pop;
      out_valid_d = 1'b0;
      pop_last    = pop & last_q[rd_addr];
    end

    wr_ptr_d = drop ? commit_ptr_q : wr_ptr_q + CNT_WIDTH'(wr_accept);
    if (!PktMode || commit) begin
      commit_ptr_d = wr_ptr_d;
    end else begin
      commit_ptr_d = commit_ptr_q;
    end
    rd_ptr_d = rd_ptr_q + CNT_WIDTH'(rd_load);

    // In fwft the word held in the output register has already left the RAM.
    out_cnt      = CNT_WIDTH'(out_valid_d);
    data_count_d = commit_ptr_d - rd_ptr_d + out_cnt;
    wr_count_d   = wr_ptr_d - rd_ptr_d + out_cnt;
    full_d       = (wr_ptr_d - rd_ptr_d) == DepthCnt;
    empty_d      = Fwft ? ~out_valid_d : (commit_ptr_d == rd_ptr_d);
    pkt_count_d  = pkt_count_q + CNT_WIDTH'(commit) - CNT_WIDTH'(pop_last);
    prog_full_d  = wr_count_d >= ProgFullCnt;
    prog_empty_d = data_count_d <= ProgEmptyCnt;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr]    <= {wr_last, din};
      last_q[wr_addr] <= wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      dout_last_q <= 1'b0;
    end else if (rd_load) begin
      {dout_last_q, dout_q} <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      commit_rd_q  <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      full_q       <= 1'b1;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      data_count_q <= '0;
      wr_count_q   <= '0;
      pkt_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      commit_rd_q  <= commit_ptr_q;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      prog_full_q  <= prog_full_d;
      prog_empty_q <= prog_empty_d;
      overflow_q   <= wr_reject;
      underflow_q  <= rd_reject;
      data_count_q <= data_count_d;
      wr_count_q   <= wr_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign dout       = dout_q;
  assign dout_last  = dout_last_q;
  assign data_count = data_count_q;
  assign wr_count   = wr_count_q;
  assign pkt_count  = pkt_count_q;
  assign prog_full  = prog_full_q;
  assign prog_empty = prog_empty_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// tb_sync_pkt_fifo: directed bench for sync_pkt_fifo. Two instances share clock and reset:
// f_* is fwft / packet mode, s_* is std / packet mode, both DEPTH=16, 16-bit data,
// prog_full threshold 12, prog_empty threshold 8.
module tb_sync_pkt_fifo;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 5;

  logic          clk, rst;

  logic          f_wr_en, f_wr_last, f_wr_drop, f_rd_en;
  logic [DW-1:0] f_din, f_dout;
  logic          f_full, f_empty, f_dout_last, f_prog_full, f_prog_empty;
  logic          f_overflow, f_underflow;
  logic [CW-1:0] f_data_count, f_wr_count, f_pkt_count;

  logic          s_wr_en, s_wr_last, s_wr_drop, s_rd_en;
  logic [DW-1:0] s_din, s_dout;
  logic          s_full, s_empty, s_dout_last, s_prog_full, s_prog_empty;
  logic          s_overflow, s_underflow;
  logic [CW-1:0] s_data_count, s_wr_count, s_pkt_count;

  int checks;
  int errors;

  sync_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(16), .READ_MODE("fwft"), .PKT_MODE(1),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(8), .CNT_WIDTH(CW)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .din(f_din), .wr_last(f_wr_last),
    .wr_drop(f_wr_drop), .full(f_full), .rd_en(f_rd_en), .dout(f_dout),
    .dout_last(f_dout_last), .empty(f_empty), .data_count(f_data_count),
    .wr_count(f_wr_count), .pkt_count(f_pkt_count), .prog_full(f_prog_full),
    .prog_empty(f_prog_empty), .overflow(f_overflow), .underflow(f_underflow)
  );

  sync_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH(16), .READ_MODE("std"), .PKT_MODE(1),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(8), .CNT_WIDTH(CW)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .din(s_din), .wr_last(s_wr_last),
    .wr_drop(s_wr_drop), .full(s_full), .rd_en(s_rd_en), .dout(s_dout),
    .dout_last(s_dout_last), .empty(s_empty), .data_count(s_data_count),
    .wr_count(s_wr_count), .pkt_count(s_pkt_count), .prog_full(s_prog_full),
    .prog_empty(s_prog_empty), .overflow(s_overflow), .underflow(s_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached expected finish");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    f_wr_en = 1'b0; f_wr_last = 1'b0; f_wr_drop = 1'b0; f_rd_en = 1'b0; f_din = '0;
    s_wr_en = 1'b0; s_wr_last = 1'b0; s_wr_drop = 1'b0; s_rd_en = 1'b0; s_din = '0;
  endtask

  // Flag vector order: {full, empty, prog_empty, prog_full, overflow, underflow, dout_last}
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    checks++;
    if ({f_full, f_empty, f_prog_empty, f_prog_full, f_overflow, f_underflow, f_dout_last}
        !== 7'b1110000) begin
      errors++;
      $display("FAIL reset_f_flags: got %b expected 1110000",
               {f_full, f_empty, f_prog_empty, f_prog_full, f_overflow, f_underflow, f_dout_last});
    end
    checks++;
    if ({s_full, s_empty, s_prog_empty, s_prog_full, s_overflow, s_underflow, s_dout_last}
        !== 7'b1110000) begin
      errors++;
      $display("FAIL reset_s_flags: got %b expected 1110000",
               {s_full, s_empty, s_prog_empty, s_prog_full, s_overflow, s_underflow, s_dout_last});
    end
    checks++;
    if ({f_data_count, f_wr_count, f_pkt_count, f_dout} !== 31'd0) begin
      errors++;
      $display("FAIL reset_f_counts: got %0d/%0d/%0d dout %h expected 0/0/0 dout 0",
               f_data_count, f_wr_count, f_pkt_count, f_dout);
    end
    checks++;
    if ({s_data_count, s_wr_count, s_pkt_count, s_dout} !== 31'd0) begin
      errors++;
      $display("FAIL reset_s_counts: got %0d/%0d/%0d dout %h expected 0/0/0 dout 0",
               s_data_count, s_wr_count, s_pkt_count, s_dout);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({f_full, s_full} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_full: got %b expected 00", {f_full, s_full});
    end
  endtask

  task automatic test_fwft_frame();
    logic [DW-1:0] exp_d;
    logic          exp_l;
    for (int i = 0; i < 4; i++) begin
      f_wr_en = 1'b1; f_din = 16'h00A0 + 16'(i); f_wr_last = (i == 3);
      step();
      checks++;
      if (f_empty !== 1'b1) begin
        errors++;
        $display("FAIL fwft_empty_write%0d: got %b expected 1", i, f_empty);
      end
    end
    f_wr_en = 1'b0; f_wr_last = 1'b0;
    checks++;
    if ({f_pkt_count, f_data_count, f_wr_count} !== {5'd1, 5'd4, 5'd4}) begin
      errors++;
      $display("FAIL fwft_commit_counts: got pkt %0d data %0d wr %0d expected 1 4 4",
               f_pkt_count, f_data_count, f_wr_count);
    end
    step();
    checks++;
    if (f_empty !== 1'b1) begin
      errors++;
      $display("FAIL fwft_empty_commit_plus1: got %b expected 1", f_empty);
    end
    step();
    checks++;
    if (f_empty !== 1'b0) begin
      errors++;
      $display("FAIL fwft_empty_commit_plus2: got %b expected 0", f_empty);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 16'h00A0 + 16'(i);
      exp_l = (i == 3);
      checks++;
      if (f_dout !== exp_d || f_dout_last !== exp_l || f_pkt_count !== 5'd1) begin
        errors++;
        $display("FAIL fwft_read%0d: got %h last %b pkt %0d expected %h last %b pkt 1",
                 i, f_dout, f_dout_last, f_pkt_count, exp_d, exp_l);
      end
      f_rd_en = 1'b1;
      step();
    end
    f_rd_en = 1'b0;
    checks++;
    if ({f_empty, f_pkt_count, f_data_count} !== {1'b1, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL fwft_drained: got empty %b pkt %0d data %0d expected 1 0 0",
               f_empty, f_pkt_count, f_data_count);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      f_wr_en = 1'b1; f_din = 16'h0090 + 16'(i); f_wr_last = 1'b0;
      step();
    end
    f_wr_en = 1'b0;
    checks++;
    if ({f_wr_count, f_data_count} !== {5'd3, 5'd0}) begin
      errors++;
      $display("FAIL drop_partial: got wr %0d data %0d expected 3 0", f_wr_count, f_data_count);
    end
    f_wr_drop = 1'b1;
    step();
    f_wr_drop = 1'b0;
    checks++;
    if ({f_wr_count, f_data_count, f_empty} !== {5'd0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL drop_rewind: got wr %0d data %0d empty %b expected 0 0 1",
               f_wr_count, f_data_count, f_empty);
    end
    f_wr_en = 1'b1; f_din = 16'h00B0; f_wr_last = 1'b0;
    step();
    f_din = 16'h00B1; f_wr_last = 1'b1;
    step();
    f_wr_en = 1'b0; f_wr_last = 1'b0;
    step();
    step();
    checks++;
    if ({f_empty, f_dout, f_dout_last} !== {1'b0, 16'h00B0, 1'b0}) begin
      errors++;
      $display("FAIL drop_next_b0: got empty %b dout %h last %b expected 0 b0 0",
               f_empty, f_dout, f_dout_last);
    end
    f_rd_en = 1'b1;
    step();
    checks++;
    if ({f_dout, f_dout_last} !== {16'h00B1, 1'b1}) begin
      errors++;
      $display("FAIL drop_next_b1: got dout %h last %b expected b1 1", f_dout, f_dout_last);
    end
    step();
    f_rd_en = 1'b0;
    checks++;
    if ({f_empty, f_pkt_count} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL drop_next_drained: got empty %b pkt %0d expected 1 0", f_empty, f_pkt_count);
    end
  endtask

  task automatic test_drop_same_cycle();
    f_wr_en = 1'b1; f_din = 16'h00C3; f_wr_last = 1'b0;
    step();
    f_din = 16'h00C4;
    step();
    f_din = 16'h00C5; f_wr_last = 1'b1; f_wr_drop = 1'b1;
    step();
    f_wr_en = 1'b0; f_wr_last = 1'b0; f_wr_drop = 1'b0;
    checks++;
    if ({f_overflow, f_pkt_count, f_wr_count, f_data_count} !== {1'b0, 5'd0, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL drop_wins: got ovf %b pkt %0d wr %0d data %0d expected 0 0 0 0",
               f_overflow, f_pkt_count, f_wr_count, f_data_count);
    end
    step();
    step();
    checks++;
    if ({f_empty, f_pkt_count} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL drop_wins_later: got empty %b pkt %0d expected 1 0", f_empty, f_pkt_count);
    end
  endtask

  task automatic test_full_wrap();
    logic [DW-1:0] exp_d;
    logic          exp_l;
    for (int i = 0; i < 16; i++) begin
      f_wr_en = 1'b1; f_din = 16'h0100 + 16'(i); f_wr_last = (i == 15);
      step();
      if (i == 14) begin
        checks++;
        if (f_full !== 1'b0) begin
          errors++;
          $display("FAIL full_at_15: got %b expected 0", f_full);
        end
      end
    end
    checks++;
    if ({f_full, f_wr_count, f_empty, f_pkt_count} !== {1'b1, 5'd16, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL full_at_16: got full %b wr %0d empty %b pkt %0d expected 1 16 1 1",
               f_full, f_wr_count, f_empty, f_pkt_count);
    end
    f_din = 16'h00EE; f_wr_last = 1'b1;
    step();
    f_wr_en = 1'b0; f_wr_last = 1'b0;
    checks++;
    if ({f_overflow, f_full, f_wr_count, f_pkt_count} !== {1'b1, 1'b1, 5'd16, 5'd1}) begin
      errors++;
      $display("FAIL overflow_pulse: got ovf %b full %b wr %0d pkt %0d expected 1 1 16 1",
               f_overflow, f_full, f_wr_count, f_pkt_count);
    end
    step();
    // Prefetch moved the head word into the output register, freeing one RAM slot.
    checks++;
    if ({f_overflow, f_empty, f_dout, f_full, f_wr_count} !==
        {1'b0, 1'b0, 16'h0100, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL after_overflow: got ovf %b empty %b dout %h full %b wr %0d expected 0 0 100 0 16",
               f_overflow, f_empty, f_dout, f_full, f_wr_count);
    end
    f_wr_en = 1'b1; f_din = 16'h0110; f_wr_last = 1'b1;
    step();
    checks++;
    if ({f_full, f_wr_count, f_pkt_count} !== {1'b1, 5'd17, 5'd2}) begin
      errors++;
      $display("FAIL refill_full: got full %b wr %0d pkt %0d expected 1 17 2",
               f_full, f_wr_count, f_pkt_count);
    end
    // Pop and write together while full: the write is rejected, the pop proceeds.
    f_din = 16'h00EE; f_rd_en = 1'b1;
    step();
    f_wr_en = 1'b0; f_wr_last = 1'b0; f_rd_en = 1'b0;
    checks++;
    if ({f_overflow, f_full, f_dout, f_wr_count, f_pkt_count} !==
        {1'b1, 1'b0, 16'h0101, 5'd16, 5'd2}) begin
      errors++;
      $display("FAIL pop_write_full: got ovf %b full %b dout %h wr %0d pkt %0d expected 1 0 101 16 2",
               f_overflow, f_full, f_dout, f_wr_count, f_pkt_count);
    end
    f_wr_en = 1'b1; f_din = 16'h0111; f_wr_last = 1'b1;
    step();
    f_wr_en = 1'b0; f_wr_last = 1'b0;
    checks++;
    if ({f_full, f_wr_count, f_pkt_count} !== {1'b1, 5'd17, 5'd3}) begin
      errors++;
      $display("FAIL wrap_write: got full %b wr %0d pkt %0d expected 1 17 3",
               f_full, f_wr_count, f_pkt_count);
    end
    for (int k = 1; k <= 17; k++) begin
      exp_d = 16'h0100 + 16'(k);
      exp_l = (k >= 15);
      checks++;
      if (f_dout !== exp_d || f_dout_last !== exp_l || f_empty !== 1'b0) begin
        errors++;
        $display("FAIL wrap_read%0d: got %h last %b empty %b expected %h last %b empty 0",
                 k, f_dout, f_dout_last, f_empty, exp_d, exp_l);
      end
      f_rd_en = 1'b1;
      step();
    end
    f_rd_en = 1'b0;
    checks++;
    if ({f_empty, f_full, f_pkt_count, f_wr_count} !== {1'b1, 1'b0, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL wrap_drained: got empty %b full %b pkt %0d wr %0d expected 1 0 0 0",
               f_empty, f_full, f_pkt_count, f_wr_count);
    end
  endtask

  task automatic test_std_mode();
    s_rd_en = 1'b1;
    step();
    s_rd_en = 1'b0;
    checks++;
    if ({s_underflow, s_empty} !== 2'b11) begin
      errors++;
      $display("FAIL std_underflow: got unf %b empty %b expected 1 1", s_underflow, s_empty);
    end
    step();
    checks++;
    if (s_underflow !== 1'b0) begin
      errors++;
      $display("FAIL std_underflow_clear: got %b expected 0", s_underflow);
    end
    s_wr_en = 1'b1; s_din = 16'h0055; s_wr_last = 1'b1;
    step();
    s_wr_en = 1'b0; s_wr_last = 1'b0;
    checks++;
    if ({s_empty, s_data_count, s_pkt_count, s_prog_empty, s_dout} !==
        {1'b0, 5'd1, 5'd1, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL std_commit: got empty %b data %0d pkt %0d pe %b dout %h expected 0 1 1 1 0",
               s_empty, s_data_count, s_pkt_count, s_prog_empty, s_dout);
    end
    s_rd_en = 1'b1;
    step();
    s_rd_en = 1'b0;
    checks++;
    if ({s_dout, s_dout_last, s_empty, s_pkt_count, s_data_count} !==
        {16'h0055, 1'b1, 1'b1, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL std_read: got dout %h last %b empty %b pkt %0d data %0d expected 55 1 1 0 0",
               s_dout, s_dout_last, s_empty, s_pkt_count, s_data_count);
    end
    for (int i = 0; i < 12; i++) begin
      s_wr_en = 1'b1; s_din = 16'h0060 + 16'(i); s_wr_last = (i == 11);
      step();
      if (i == 10) begin
        checks++;
        if ({s_prog_full, s_prog_empty, s_wr_count} !== {1'b0, 1'b1, 5'd11}) begin
          errors++;
          $display("FAIL std_prog_11: got pf %b pe %b wr %0d expected 0 1 11",
                   s_prog_full, s_prog_empty, s_wr_count);
        end
      end
    end
    s_wr_en = 1'b0; s_wr_last = 1'b0;
    checks++;
    if ({s_prog_full, s_prog_empty, s_wr_count, s_data_count} !==
        {1'b1, 1'b0, 5'd12, 5'd12}) begin
      errors++;
      $display("FAIL std_prog_12: got pf %b pe %b wr %0d data %0d expected 1 0 12 12",
               s_prog_full, s_prog_empty, s_wr_count, s_data_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      s_wr_en = 1'b1; s_din = 16'h0070 + 16'(i); s_wr_last = (i < 5);
      step();
    end
    s_wr_en = 1'b0; s_wr_last = 1'b0;
    checks++;
    if ({s_data_count, s_wr_count, s_pkt_count, s_empty} !== {5'd5, 5'd7, 5'd5, 1'b0}) begin
      errors++;
      $display("FAIL mid_frame_fill: got data %0d wr %0d pkt %0d empty %b expected 5 7 5 0",
               s_data_count, s_wr_count, s_pkt_count, s_empty);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({s_full, s_empty, s_prog_empty, s_prog_full, s_data_count, s_wr_count, s_pkt_count}
        !== {4'b1110, 15'd0}) begin
      errors++;
      $display("FAIL mid_frame_reset: got flags %b counts %0d/%0d/%0d expected 1110 0/0/0",
               {s_full, s_empty, s_prog_empty, s_prog_full}, s_data_count, s_wr_count,
               s_pkt_count);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({s_full, s_empty, s_wr_count} !== {1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL mid_frame_release: got full %b empty %b wr %0d expected 0 1 0",
               s_full, s_empty, s_wr_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fwft_frame();
    test_drop();
    test_drop_same_cycle();
    test_full_wrap();
    test_std_mode();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
